rf_wb_buffer: RTL

Write-back buffer that sits directly upstream of the 32 x 32 register file and drives its single write port (`we`, `waddr`, `wdata`). It merges two result producers: the single-cycle ALU, which always has priority, and the multi-cycle multiply/divide unit (MDU), whose results queue in a small FIFO until the write port is free. The block also reports pending writes back to the issue stage so that readers of `raddr1`/`raddr2` can stall, or take forwarded data when bypass is compiled in.

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_wb_fifo.sv | 80 ++++++++
 rtl/rf_wb_buffer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-back path.
// Default widths, the write-back bundle type and the hard-wired zero register.
package rf_pkg;

    localparam int RF_AW       = 5;
    localparam int RF_DW       = 32;
    localparam int RF_ZERO_REG = 0;

    typedef struct packed {
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
    } rf_wb_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO for queued MDU write-backs.
// Exposes its occupancy, read pointer and a flat view of every slot.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [AW-1:0]            push_addr_i,
    input  logic [DW-1:0]            push_data_i,
    input  logic                     pop_i,
    output logic [AW-1:0]            head_addr_o,
    output logic [DW-1:0]            head_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [$clog2(DEPTH)-1:0] rd_ptr_o,
    output logic [DEPTH-1:0]         ent_valid_o,
    output logic [DEPTH*AW-1:0]      ent_addr_o,
    output logic [DEPTH*DW-1:0]      ent_data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_i && !pop_i) count_d = count_q + 1'b1;
        if (!push_i && pop_i) count_d = count_q - 1'b1;
    end

    // Control state, cleared by reset so queued results are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Slot storage; validity comes from count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign count_o     = count_q;
    assign rd_ptr_o    = rd_ptr_q;

    // A slot is live when its distance from the head is below count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid_o[i] = {1'b0, PW'(i) - rd_ptr_q} < count_q;
            ent_addr_o[i*AW +: AW] = addr_q[i];
            ent_data_o[i*DW +: DW] = data_q[i];
        end
    end

endmodule

// File: rtl/rf_wb_buffer.sv
// Write-back buffer merging ALU (priority) and queued MDU results.
// Optional forwarding of in-flight data is built with RF_WB_BYPASS_EN.
module rf_wb_buffer
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [AW-1:0]          alu_waddr,
    input  logic [DW-1:0]          alu_wdata,
    input  logic                   mdu_valid,
    output logic                   mdu_ready,
    input  logic [AW-1:0]          mdu_waddr,
    input  logic [DW-1:0]          mdu_wdata,
    output logic                   rf_we,
    output logic [AW-1:0]          rf_waddr,
    output logic [DW-1:0]          rf_wdata,
    input  logic [AW-1:0]          raddr1,
    input  logic [AW-1:0]          raddr2,
    output logic                   pend1,
    output logic                   pend2,
    output logic [$clog2(DEPTH):0] count
`ifdef RF_WB_BYPASS_EN
    ,
    output logic [DW-1:0]          byp1_data,
    output logic [DW-1:0]          byp2_data
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW-1:0] ZERO = AW'(RF_ZERO_REG);

    logic                alu_take, push, pop;
    logic [AW-1:0]       head_addr;
    logic [DW-1:0]       head_data;
    logic [PW-1:0]       rd_ptr;
    logic [DEPTH-1:0]    ent_valid;
    logic [DEPTH*AW-1:0] ent_addr;
    logic [DEPTH*DW-1:0] ent_data;
    logic                we_q, we_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [AW-1:0]       ra [2];
    logic [1:0]          pend_v;

    assign alu_take  = alu_valid && (alu_waddr != ZERO);
    assign mdu_ready = count < CW'(DEPTH);
    assign push      = mdu_valid && mdu_ready && (mdu_waddr != ZERO);
    assign pop       = !alu_take && (count != '0);

    rf_wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_addr_i (mdu_waddr),
        .push_data_i (mdu_wdata),
        .pop_i       (pop),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .count_o     (count),
        .rd_ptr_o    (rd_ptr),
        .ent_valid_o (ent_valid),
        .ent_addr_o  (ent_addr),
        .ent_data_o  (ent_data)
    );

    // Port arbitration: ALU first, then FIFO head, else idle and hold.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (alu_take) begin
            we_d    = 1'b1;
            waddr_d = alu_waddr;
            wdata_d = alu_wdata;
        end else if (pop) begin
            we_d    = 1'b1;
            waddr_d = head_addr;
            wdata_d = head_data;
        end
    end

    // Registered write port toward the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign rf_we    = we_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign ra[0]    = raddr1;
    assign ra[1]    = raddr2;

    // Pending lookup against the output register and every live slot.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            pend_v[p] = we_q && (waddr_q == ra[p]);
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_valid[i] && (ent_addr[i*AW +: AW] == ra[p]))
                    pend_v[p] = 1'b1;
            end
            if (ra[p] == ZERO) pend_v[p] = 1'b0;
        end
    end

    assign pend1 = pend_v[0];
    assign pend2 = pend_v[1];

`ifdef RF_WB_BYPASS_EN
    logic [DW-1:0] byp_v [2];
    logic [PW-1:0] idx;

    // Forward the youngest match: output register, then head to tail.
    always_comb begin
        idx = '0;
        for (int p = 0; p < 2; p++) begin
            byp_v[p] = '0;
            if (we_q && (waddr_q == ra[p])) byp_v[p] = wdata_q;
            for (int k = 0; k < DEPTH; k++) begin
                idx = rd_ptr + PW'(k);
                if ((CW'(k) < count) && (ent_addr[idx*AW +: AW] == ra[p]))
                    byp_v[p] = ent_data[idx*DW +: DW];
            end
            if (!pend_v[p]) byp_v[p] = '0;
        end
    end

    assign byp1_data = byp_v[0];
    assign byp2_data = byp_v[1];
`else
    logic unused_fifo_view;
    assign unused_fifo_view = ^{ent_data, rd_ptr};
`endif

endmodule
